// File: rtl/drm_bist_pkg.sv
// rtl/drm_bist_pkg.sv - shared state/mode types and pattern function for drm_bist
package drm_bist_pkg;

    // Widest RAM word supported; patterns are built at this width and truncated.
    localparam int PAT_MAX_W = 1152;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_DEC  = 2'd0,
        MODE_ADDR = 2'd1,
        MODE_CHK  = 2'd2,
        MODE_ONES = 2'd3
    } mode_e;

    // Full-width pattern for address a; truncating to N bits gives the N-bit pattern
    // because every mode is LSB-aligned (~a mod 2**N == all-ones minus a mod 2**N).
    function automatic logic [PAT_MAX_W-1:0] pat_fn(input mode_e m, input logic [63:0] a);
        logic [PAT_MAX_W-1:0] ax;
        logic [PAT_MAX_W-1:0] chk;
        ax  = PAT_MAX_W'(a);
        chk = {(PAT_MAX_W/2){2'b01}};
        case (m)
            MODE_DEC:  pat_fn = ~ax;
            MODE_ADDR: pat_fn = ax;
            MODE_CHK:  pat_fn = a[0] ? ~chk : chk;
            default:   pat_fn = '1;
        endcase
    endfunction

endpackage

// File: rtl/drm_bist_pat.sv
// rtl/drm_bist_pat.sv - combinational test pattern generator
module drm_bist_pat
    import drm_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 21
) (
    input  mode_e                 i_mode,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    // Pattern word for the given address in the selected mode.
    always_comb begin
        o_data = DATA_WIDTH'(pat_fn(i_mode, 64'(i_addr)));
    end

endmodule

// File: rtl/drm_bist.sv
// rtl/drm_bist.sv - write/read/compare memory BIST engine for an external RAM
module drm_bist
    import drm_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 21,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     ram_wr_en,
    output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic                     ram_rd_en,
    output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data
);

    localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR  = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;
    localparam logic [1:0]               DRAIN_LAST = 2'(RD_LATENCY);

    state_e                     r_state;
    state_e                     w_next;
    mode_e                      r_mode;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic [1:0]                 r_drain_cnt;
    logic [RD_LATENCY-1:0]      r_vld;
    logic [ADDR_WIDTH-1:0]      r_vaddr [RD_LATENCY];
    logic                       r_mis;
    logic [ADDR_WIDTH-1:0]      r_mis_addr;
    logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;
    logic [ADDR_WIDTH-1:0]      r_first_addr;
    logic                       w_start_acc;
    logic                       w_in_write;
    logic                       w_in_read;
    logic [DATA_WIDTH-1:0]      w_wr_pat;
    logic [DATA_WIDTH-1:0]      w_exp_pat;

    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_in_write  = (r_state == ST_WRITE);
    assign w_in_read   = (r_state == ST_READ);

    assign busy           = w_in_write || w_in_read || (r_state == ST_DRAIN);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_err_cnt == '0);
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_addr;
    assign ram_wr_en      = w_in_write;
    assign ram_rd_en      = w_in_read;
    assign ram_wr_addr    = r_addr;
    assign ram_rd_addr    = r_addr;
    assign ram_wr_data    = w_in_write ? w_wr_pat : '0;

    drm_bist_pat #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pat_wr (
        .i_mode (r_mode),
        .i_addr (r_addr),
        .o_data (w_wr_pat)
    );

    drm_bist_pat #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_pat_exp (
        .i_mode (r_mode),
        .i_addr (r_vaddr[RD_LATENCY-1]),
        .o_data (w_exp_pat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one full write sweep, one full read sweep, then wait out the read pipeline.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_acc) w_next = ST_WRITE;
            ST_WRITE:         if (r_addr == LAST_ADDR) w_next = ST_READ;
            ST_READ:          if (r_addr == LAST_ADDR) w_next = ST_DRAIN;
            ST_DRAIN:         if (r_drain_cnt == DRAIN_LAST) w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    // Shared sweep address (wraps to 0 between WRITE and READ), drain timer and mode capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_drain_cnt <= '0;
            r_mode      <= MODE_DEC;
        end else begin
            if (w_start_acc) begin
                r_addr      <= '0;
                r_drain_cnt <= '0;
                r_mode      <= mode_e'(mode);
            end else if (w_in_write || w_in_read) begin
                r_addr <= r_addr + 1'b1;
            end
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
        end
    end

    // Read-valid/address pipeline aligning expected data with RAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_vaddr[i] <= '0;
            end
        end else begin
            r_vld[0]   <= w_in_read;
            r_vaddr[0] <= r_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_vaddr[i] <= r_vaddr[i-1];
            end
        end
    end

    // Registered compare of returned data against the expected pattern.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_mis      <= 1'b0;
            r_mis_addr <= '0;
        end else begin
            r_mis      <= r_vld[RD_LATENCY-1] && (ram_rd_data != w_exp_pat);
            r_mis_addr <= r_vaddr[RD_LATENCY-1];
        end
    end

    // Saturating error count; a zero count means no mismatch seen yet, so it gates first-address capture.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_err_cnt    <= '0;
            r_first_addr <= '0;
        end else if (r_mis) begin
            if (r_err_cnt != ERR_MAX) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (r_err_cnt == '0) begin
                r_first_addr <= r_mis_addr;
            end
        end
    end

endmodule

// File: tb/tb_drm_bist.sv
// tb/tb_drm_bist.sv - self-checking bench for drm_bist at read latency 1 and 2
module tb_drm_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [1:0]            start, busy, done, pass, wr_en, rd_en;
    logic [1:0][1:0]       mode;
    logic [1:0][2:0]       err_cnt;
    logic [1:0][5:0]       first, wr_addr, rd_addr;
    logic [1:0][20:0]      wr_data, rd_data, p1, p2;
    logic [20:0]           mem  [2][64];
    logic [20:0]           orm  [64];
    logic [20:0]           andm [64];

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    int wexp [2];
    int rexp [2];
    logic [1:0] prev_wr = 2'b00;

    drm_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(21), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]),
        .first_err_addr(first[0]), .ram_wr_en(wr_en[0]), .ram_wr_addr(wr_addr[0]),
        .ram_wr_data(wr_data[0]), .ram_rd_en(rd_en[0]), .ram_rd_addr(rd_addr[0]),
        .ram_rd_data(rd_data[0])
    );

    drm_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(21), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]),
        .first_err_addr(first[1]), .ram_wr_en(wr_en[1]), .ram_wr_addr(wr_addr[1]),
        .ram_wr_data(wr_data[1]), .ram_rd_en(rd_en[1]), .ram_rd_addr(rd_addr[1]),
        .ram_rd_data(rd_data[1])
    );

    // RAM models: instance 0 returns data one cycle after the read, instance 1 two cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) mem[i][wr_addr[i]] <= wr_data[i];
            if (rd_en[i]) p1[i] <= (mem[i][rd_addr[i]] | orm[rd_addr[i]]) & ~andm[rd_addr[i]];
            p2[i] <= p1[i];
        end
    end
    assign rd_data = {p2[1], p1[0]};

    // Sweep protocol monitor: ordered gap-free writes then reads, never both, nothing while idle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!busy[i]) begin
                wexp[i] = 0;
                rexp[i] = 0;
                if (wr_en[i] || rd_en[i]) viol++;
            end else begin
                if (wr_en[i] && rd_en[i]) viol++;
                if (wr_en[i]) begin
                    if (32'(wr_addr[i]) != wexp[i]) viol++;
                    wexp[i]++;
                end
                if (rd_en[i]) begin
                    if (32'(rd_addr[i]) != rexp[i] || wexp[i] != 64) viol++;
                    if (rexp[i] == 0 && !prev_wr[i]) viol++;
                    rexp[i]++;
                end
            end
            prev_wr[i] = wr_en[i];
        end
    end

    typedef struct {
        int inst;
        int m;
        int fault;
        int cyc;
        int pass;
        int err;
        int first;
    } tvec_t;

    tvec_t tbl [8];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int i);
        return 64'({busy[i], done[i], pass[i], err_cnt[i], first[i], wr_en[i], wr_addr[i],
                    wr_data[i], rd_en[i], rd_addr[i]});
    endfunction

    function automatic logic [20:0] pat(input int m, input int a);
        logic [20:0] r;
        case (m)
            0: r = 21'((2 ** 21) - 1 - a);
            1: r = 21'(a);
            2: for (int b = 0; b < 21; b++) r[b] = ((b % 2) == 0) ^ ((a % 2) == 1);
            default: r = '1;
        endcase
        return r;
    endfunction

    // Reference: count addresses whose faulty readback differs from the pattern, saturated at 7.
    task automatic model(input int m, output int e, output int f);
        e = 0;
        f = 0;
        for (int a = 0; a < 64; a++) begin
            if (((pat(m, a) | orm[a]) & ~andm[a]) != pat(m, a)) begin
                if (e == 0) f = a;
                e++;
            end
        end
        if (e > 7) e = 7;
    endtask

    task automatic set_fault(input int id);
        for (int a = 0; a < 64; a++) begin
            orm[a]  = '0;
            andm[a] = (id == 2) ? '1 : '0;
        end
        if (id == 1) orm[5]  = 21'h1;
        if (id == 3) andm[5] = 21'h1;
    endtask

    task automatic kick(input int inst, input int m);
        @(negedge clk);
        start[inst] = 1'b1;
        mode[inst]  = 2'(m);
        @(posedge clk);
        @(negedge clk);
        start[inst] = 1'b0;
    endtask

    // Counts edges from the one that accepted start; scrambles mode and optionally pulses start meanwhile.
    task automatic wait_done(input int inst, input int glitch, output int cyc);
        cyc = 1;
        while (!done[inst] && cyc < 1000) begin
            mode[inst]  = 2'($urandom);
            start[inst] = (cyc == glitch);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start[inst] = 1'b0;
        chk("done_reached", inst, 64'(done[inst]), 64'd1);
    endtask

    initial begin
        int cyc, e, f, inst, m;

        tbl[0] = '{0, 0, 0, 131, 1, 0, 0};
        tbl[1] = '{1, 2, 0, 132, 1, 0, 0};
        tbl[2] = '{0, 1, 3, 131, 0, 1, 5};
        tbl[3] = '{0, 3, 2, 131, 0, 7, 0};
        tbl[4] = '{0, 1, 1, 131, 1, 0, 0};
        tbl[5] = '{1, 0, 1, 132, 0, 1, 5};
        tbl[6] = '{0, 1, 2, 131, 0, 7, 1};
        tbl[7] = '{1, 3, 3, 132, 0, 1, 5};

        rst_n = 1'b0;
        start = '0;
        mode  = '0;
        set_fault(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", 0, outs(0), 64'd0);
        chk("reset_outs", 1, outs(1), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            set_fault(tbl[k].fault);
            kick(tbl[k].inst, tbl[k].m);
            wait_done(tbl[k].inst, -1, cyc);
            chk("tbl_cycles", k, 64'(cyc), 64'(tbl[k].cyc));
            chk("tbl_pass",   k, 64'(pass[tbl[k].inst]), 64'(tbl[k].pass));
            chk("tbl_err",    k, 64'(err_cnt[tbl[k].inst]), 64'(tbl[k].err));
            chk("tbl_first",  k, 64'(first[tbl[k].inst]), 64'(tbl[k].first));
            if (k == 0) begin
                chk("wr_word_a0",  k, 64'(mem[0][0]),  64'h1FFFFF);
                chk("wr_word_a63", k, 64'(mem[0][63]), 64'h1FFFC0);
            end
        end

        // Reset in the middle of a run.
        set_fault(0);
        kick(0, 0);
        for (int c = 0; c < 39; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrun_reset_outs", 0, outs(0), 64'd0);
        rst_n = 1'b1;
        kick(0, 1);
        wait_done(0, -1, cyc);
        chk("post_reset_cycles", 0, 64'(cyc), 64'd131);
        chk("post_reset_pass",   0, 64'(pass[0]), 64'd1);

        // Start pulsed during READ is ignored; start in DONE restarts with cleared results.
        set_fault(2);
        kick(0, 3);
        wait_done(0, 90, cyc);
        chk("ignored_start_cycles", 0, 64'(cyc), 64'd131);
        chk("ignored_start_err",    0, 64'(err_cnt[0]), 64'd7);
        set_fault(0);
        kick(0, 0);
        chk("restart_state", 0, 64'({busy[0], done[0], pass[0], err_cnt[0], first[0]}),
            64'({1'b1, 1'b0, 1'b0, 3'd0, 6'd0}));
        wait_done(0, -1, cyc);
        chk("restart_cycles", 0, 64'(cyc), 64'd131);
        chk("restart_pass",   0, 64'(pass[0]), 64'd1);

        // Randomized fault maps checked against the reference model.
        for (int r = 0; r < 8; r++) begin
            inst = $urandom_range(0, 1);
            m    = $urandom_range(0, 3);
            for (int a = 0; a < 64; a++) begin
                orm[a]  = ($urandom_range(0, 7) == 0) ? 21'($urandom) : 21'd0;
                andm[a] = ($urandom_range(0, 7) == 0) ? 21'($urandom) : 21'd0;
            end
            model(m, e, f);
            kick(inst, m);
            wait_done(inst, -1, cyc);
            chk("rnd_cycles", r, 64'(cyc), 64'(131 + inst));
            chk("rnd_pass",   r, 64'(pass[inst]), 64'(e == 0));
            chk("rnd_err",    r, 64'(err_cnt[inst]), 64'(e));
            chk("rnd_first",  r, 64'(first[inst]), 64'(f));
        end

        chk("sweep_protocol_violations", 0, 64'(viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
